// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus constants and the sprite-DMA state encoding.
package nes_bus_pkg;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_e;

endpackage

// File: rtl/nes_oam_dma_if.sv
// Bus-snoop and sprite-DMA request/grant signals between the DMA and the arbiter.
interface nes_oam_dma_if;

    logic [15:0] i_bus_addr;
    logic        i_bus_wn;
    logic [7:0]  i_bus_wdata;
    logic        o_spr_req;
    logic        i_spr_gnt;
    logic [15:0] o_spr_addr;
    logic        o_spr_wn;
    logic [7:0]  o_spr_wdata;
    logic [7:0]  i_spr_rdata;
    logic        o_dma_busy;

    // DMA engine side
    modport master (
        input  i_bus_addr, i_bus_wn, i_bus_wdata, i_spr_gnt, i_spr_rdata,
        output o_spr_req, o_spr_addr, o_spr_wn, o_spr_wdata, o_dma_busy
    );

    // Arbiter / system side
    modport slave (
        output i_bus_addr, i_bus_wn, i_bus_wdata, i_spr_gnt, i_spr_rdata,
        input  o_spr_req, o_spr_addr, o_spr_wn, o_spr_wdata, o_dma_busy
    );

endinterface

// File: rtl/nes_oam_dma.sv
// NES sprite DMA: on a write to $4014 copies page PAGE ($xx00..$xxFF) into OAMDATA ($2004).
// All bus outputs are registered from the next-state values so they change only on granted edges.
module nes_oam_dma
    import nes_bus_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    nes_oam_dma_if.master bus
);

    dma_state_e  state, state_nxt;
    logic [7:0]  page, page_nxt;
    logic [7:0]  idx, idx_nxt;
    logic [7:0]  data, data_nxt;
    logic        parity;
    logic        trigger;

    logic        req_nxt;
    logic        busy_nxt;
    logic [15:0] addr_nxt;
    logic        wn_nxt;
    logic [7:0]  wdata_nxt;

    assign trigger = !bus.i_bus_wn && (bus.i_bus_addr == ADDR_OAMDMA)
                     && !bus.o_spr_req && !bus.o_dma_busy;

    // State, datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= DMA_IDLE;
            page            <= 8'h00;
            idx             <= 8'h00;
            data            <= 8'h00;
            parity          <= 1'b0;
            bus.o_spr_req   <= 1'b0;
            bus.o_dma_busy  <= 1'b0;
            bus.o_spr_addr  <= 16'h0000;
            bus.o_spr_wn    <= 1'b1;
            bus.o_spr_wdata <= 8'h00;
        end else begin
            state           <= state_nxt;
            page            <= page_nxt;
            idx             <= idx_nxt;
            data            <= data_nxt;
            parity          <= ~parity;
            bus.o_spr_req   <= req_nxt;
            bus.o_dma_busy  <= busy_nxt;
            bus.o_spr_addr  <= addr_nxt;
            bus.o_spr_wn    <= wn_nxt;
            bus.o_spr_wdata <= wdata_nxt;
        end
    end

    // Next state: nothing advances on a cycle the arbiter withholds the grant
    always_comb begin
        state_nxt = state;
        page_nxt  = page;
        idx_nxt   = idx;
        data_nxt  = data;
        case (state)
            DMA_IDLE: begin
                if (trigger) begin
                    state_nxt = DMA_HALT;
                    page_nxt  = bus.i_bus_wdata;
                    idx_nxt   = 8'h00;
                end
            end
            DMA_HALT: begin
                if (bus.i_spr_gnt) begin
                    state_nxt = parity ? DMA_ALIGN : DMA_READ;
                end
            end
            DMA_ALIGN: begin
                if (bus.i_spr_gnt) begin
                    state_nxt = DMA_READ;
                end
            end
            DMA_READ: begin
                if (bus.i_spr_gnt) begin
                    data_nxt  = bus.i_spr_rdata;
                    state_nxt = DMA_WRITE;
                end
            end
            DMA_WRITE: begin
                if (bus.i_spr_gnt) begin
                    idx_nxt   = idx + 8'd1;
                    state_nxt = (idx == 8'hFF) ? DMA_IDLE : DMA_READ;
                end
            end
            default: state_nxt = DMA_IDLE;
        endcase
    end

    // Output decode of the upcoming state; registered above
    always_comb begin
        req_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        addr_nxt  = 16'h0000;
        wn_nxt    = 1'b1;
        wdata_nxt = 8'h00;
        case (state_nxt)
            DMA_HALT, DMA_ALIGN: begin
                req_nxt  = 1'b1;
                busy_nxt = 1'b1;
                addr_nxt = ADDR_OAMDMA;
            end
            DMA_READ: begin
                req_nxt  = 1'b1;
                busy_nxt = 1'b1;
                addr_nxt = {page_nxt, idx_nxt};
            end
            DMA_WRITE: begin
                req_nxt   = 1'b1;
                busy_nxt  = 1'b1;
                addr_nxt  = ADDR_OAMDATA;
                wn_nxt    = 1'b0;
                wdata_nxt = data_nxt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nes_oam_dma.sv
// Directed bench for nes_oam_dma: full transfers at both parities, grant stealing,
// ignored retrigger, mid-transfer reset and the $FFxx page.
module tb_nes_oam_dma;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   busy_n   = 0;
    bit   par      = 1'b0;

    nes_oam_dma_if bus_if();

    nes_oam_dma dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_if.master)
    );

    always #5 clk = ~clk;

    // Sprite RAM contents as a fixed function of the address
    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ {a[3:0], a[15:12]} ^ 8'h3C;
    endfunction

    assign bus_if.i_spr_rdata = mem(bus_if.o_spr_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        bit r;
        r = rst;
        @(posedge clk);
        #1;
        par = r ? 1'b0 : ~par;
    endtask

    task automatic bus_idle();
        bus_if.i_bus_addr  = 16'h0000;
        bus_if.i_bus_wn    = 1'b1;
        bus_if.i_bus_wdata = 8'h00;
    endtask

    task automatic cyc(input string tag, input logic [15:0] a, input logic wn, input logic [7:0] wd);
        chk({tag, "_req"},   bus_if.o_spr_req,   1'b1);
        chk({tag, "_busy"},  bus_if.o_dma_busy,  1'b1);
        chk({tag, "_addr"},  bus_if.o_spr_addr,  a);
        chk({tag, "_wn"},    bus_if.o_spr_wn,    wn);
        chk({tag, "_wdata"}, bus_if.o_spr_wdata, wd);
        if (bus_if.o_dma_busy === 1'b1) busy_n++;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req"},   bus_if.o_spr_req,   1'b0);
        chk({tag, "_busy"},  bus_if.o_dma_busy,  1'b0);
        chk({tag, "_addr"},  bus_if.o_spr_addr,  16'h0000);
        chk({tag, "_wn"},    bus_if.o_spr_wn,    1'b1);
        chk({tag, "_wdata"}, bus_if.o_spr_wdata, 8'h00);
    endtask

    // One DMA run; halt_par is the parity seen during the HALT cycle.
    // Index arguments of -1 disable stealing, retriggering or aborting.
    task automatic do_dma(input string name, input logic [7:0] pg, input bit halt_par,
                          input int steal_idx, input int steal_len,
                          input int retrig_idx, input int abort_idx);
        logic [15:0] ra;
        int          exp_len;
        if (par == halt_par) step();
        busy_n = 0;
        bus_if.i_bus_addr  = 16'h4014;
        bus_if.i_bus_wn    = 1'b0;
        bus_if.i_bus_wdata = pg;
        chk({name, "_trig_busy"}, bus_if.o_dma_busy, 1'b0);
        step();
        bus_idle();
        cyc({name, "_halt"}, 16'h4014, 1'b1, 8'h00);
        step();
        if (halt_par) begin
            cyc({name, "_align"}, 16'h4014, 1'b1, 8'h00);
            step();
        end
        for (int i = 0; i < 256; i++) begin
            ra = {pg, i[7:0]};
            if (i == abort_idx) begin
                cyc($sformatf("%s_rd%0d", name, i), ra, 1'b1, 8'h00);
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk_idle({name, "_abort"});
                return;
            end
            if (i == steal_idx) begin
                bus_if.i_spr_gnt = 1'b0;
                for (int s = 0; s < steal_len; s++) begin
                    cyc($sformatf("%s_steal%0d", name, s), ra, 1'b1, 8'h00);
                    step();
                end
                bus_if.i_spr_gnt = 1'b1;
            end
            if (i == retrig_idx) begin
                bus_if.i_bus_addr  = 16'h4014;
                bus_if.i_bus_wn    = 1'b0;
                bus_if.i_bus_wdata = 8'hAA;
            end
            cyc($sformatf("%s_rd%0d", name, i), ra, 1'b1, 8'h00);
            step();
            bus_idle();
            cyc($sformatf("%s_wr%0d", name, i), 16'h2004, 1'b0, mem(ra));
            step();
        end
        chk_idle({name, "_end"});
        exp_len = 513 + (halt_par ? 1 : 0) + ((steal_idx >= 0) ? steal_len : 0);
        chk({name, "_busy_len"}, busy_n, exp_len);
    endtask

    initial begin
        bus_idle();
        bus_if.i_spr_gnt = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_idle("reset");

        // A read of $4014 and a write to $4015 must not start a transfer
        bus_if.i_bus_addr = 16'h4014;
        bus_if.i_bus_wn   = 1'b1;
        step();
        bus_if.i_bus_addr  = 16'h4015;
        bus_if.i_bus_wn    = 1'b0;
        bus_if.i_bus_wdata = 8'h02;
        step();
        bus_idle();
        step();
        chk_idle("no_trig");

        do_dma("p0",     8'h02, 1'b0, -1, 0, -1, -1);
        step();
        do_dma("p1",     8'h02, 1'b1, -1, 0, -1, -1);
        step();
        do_dma("steal",  8'h02, 1'b0, 16, 4, -1, -1);
        step();
        do_dma("retrig", 8'h05, 1'b1, -1, 0, 64, -1);
        step();
        do_dma("abort",  8'h02, 1'b0, -1, 0, -1, 128);
        do_dma("after",  8'h03, 1'b0, -1, 0, -1, -1);
        step();
        do_dma("pgff",   8'hFF, 1'b1, -1, 0, -1, -1);
        step();
        chk_idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
